vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter P_H_FRONT, default 16, horizontal front porch in pixels.
REQ-002 Parameter P_H_SYNC, default 96, horizontal sync width in pixels.
REQ-003 Parameter P_H_BACK, default 48, horizontal back porch in pixels.
REQ-004 Parameter P_V_FRONT, default 10, vertical front porch in lines.
REQ-005 Parameter P_V_SYNC, default 2, vertical sync width in lines.
REQ-006 Parameter P_V_BACK, default 33, vertical back porch in lines.
REQ-007 i_Clk  input  1  pixel clock; one clock, all logic on its rising edge.
REQ-008 i_Reset  input  1  reset; synchronous, active-high.
REQ-009 o_HBlank  output  1  high while the horizontal position is outside the visible area.
REQ-010 o_VBlank  output  1  high while the vertical position is outside the visible area.
REQ-011 o_HReset  output  1  one-cycle pulse on the last pixel of every line.
REQ-012 o_VReset  output  1  one-cycle pulse on the last pixel of the last line of every frame.
REQ-013 o_HSync  output  1  horizontal sync, active-low.
REQ-014 o_VSync  output  1  vertical sync, active-low.
REQ-015 o_Col  output  10  current pixel column, 0..H_TOTAL-1.
REQ-016 o_Row  output  10  current line, 0..V_TOTAL-1.
REQ-017 o_Frame  output  8  frame counter; wraps 255->0.

Function
REQ-018 H_TOTAL = `H_VISIBLE_AREA + P_H_FRONT + P_H_SYNC + P_H_BACK (800 by default); V_TOTAL = `V_VISIBLE_AREA + P_V_FRONT + P_V_SYNC + P_V_BACK (525 by default).
REQ-019 o_Col increments by 1 every clock and wraps from H_TOTAL-1 to 0.
REQ-020 o_Row increments by 1 on each o_Col wrap and wraps from V_TOTAL-1 to 0 when o_Col also wraps.
REQ-021 o_Frame increments by 1 on the same cycle o_Row wraps to 0.
REQ-022 All outputs are registers that decode the same counter state, so every flag is coincident with its o_Col/o_Row value and has zero skew.
REQ-023 o_HBlank = (o_Col >= `H_VISIBLE_AREA).
REQ-024 o_VBlank = (o_Row >= `V_VISIBLE_AREA).
REQ-025 o_HReset = (o_Col == H_TOTAL-1), for every line including blanked lines.
REQ-026 o_VReset = (o_Col == H_TOTAL-1 && o_Row == V_TOTAL-1); it asserts on the same cycle as an o_HReset pulse.
REQ-027 o_HSync is low for o_Col in [`H_VISIBLE_AREA+P_H_FRONT, `H_VISIBLE_AREA+P_H_FRONT+P_H_SYNC-1] (656..751 by default) and high otherwise.
REQ-028 o_VSync is low for o_Row in [`V_VISIBLE_AREA+P_V_FRONT, `V_VISIBLE_AREA+P_V_FRONT+P_V_SYNC-1] (490..491 by default) and high otherwise; it is aligned to the line boundary, not to a pixel.
REQ-029 Per line there are exactly `H_VISIBLE_AREA cycles with o_HBlank low; per frame there are exactly `V_VISIBLE_AREA lines with o_VBlank low.
REQ-030 Counter arithmetic is unsigned, 10 bits; counters never hold a value >= their TOTAL.

Reset
REQ-031 While i_Reset is high at a clock edge, the next state is o_Col=0, o_Row=0, o_Frame=0, o_HBlank=0, o_VBlank=0, o_HReset=0, o_VReset=0, o_HSync=1, o_VSync=1.
REQ-032 Reset applied mid-line or mid-frame takes effect on the next edge with no partial pulse, and counting resumes from (0,0) on the first edge after deassertion.
REQ-033 There is no asynchronous reset path; initial register values equal the reset values.

Structure
REQ-034 H_TOTAL, V_TOTAL, sync start/end positions and the visible-area constants live in the shared timing include (VgaTiming.v), next to `H_VISIBLE_AREA and `V_VISIBLE_AREA.
REQ-035 One sub-module, timing_counter (parameters TOTAL, VIS, SYNC_START, SYNC_END; inputs clock, reset, enable; outputs count, blank, sync_n, last), is instantiated once for horizontal and once for vertical; the vertical instance is enabled by the horizontal "last".

Verification
REQ-036 Reset, then release, then 800 clocks -> o_Col runs 0..799; o_HBlank rises at o_Col=640; o_HSync is low at 656..751; o_HReset is high only at o_Col=799.
REQ-037 420000 clocks (one frame) -> o_VBlank high for o_Row 480..524; o_VSync low for rows 490..491; o_VReset high exactly once, at (799,524); o_Frame increments 0->1 on the next edge.
REQ-038 Count o_HBlank-low cycles per line and o_VBlank-low lines per frame -> exactly 640 and 480.
REQ-039 Assert i_Reset for 1 cycle at (700,300) -> next cycle all outputs equal the REQ-031 values; counting restarts at (0,0).
REQ-040 Run 256 frames -> o_Frame wraps 255->0 coincident with o_Row wrap, and o_Col/o_Row never exceed 799/524 (assertion).
REQ-041 Drive a Ball instance from the outputs for 3 frames -> the ball video is asserted only while o_HBlank=0 and o_VBlank=0, and the ball position advances once per frame.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants: visible area and counter widths used by the
// timing generator and its per-axis counters.
package vga_timing_gen_pkg;

  localparam int H_VISIBLE_AREA = 640;
  localparam int V_VISIBLE_AREA = 480;
  localparam int CNT_W          = 10;
  localparam int FRAME_W        = 8;

endpackage

// File: rtl/timing_counter.sv
// One axis of the VGA raster: a wrapping position counter with registered
// blank / active-low sync / last-position flags decoded from the same state.
module timing_counter
  import vga_timing_gen_pkg::*;
#(
  parameter int TOTAL      = 800,
  parameter int VIS        = 640,
  parameter int SYNC_START = 656,
  parameter int SYNC_END   = 751
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             blank,
  output logic             sync_n,
  output logic             last
);

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] L_VIS  = CNT_W'(VIS);
  localparam logic [CNT_W-1:0] L_SS   = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] L_SE   = CNT_W'(SYNC_END);

  logic [CNT_W-1:0] nxt;

  always_comb begin
    nxt = count;
    if (enable) begin
      nxt = (count == L_LAST) ? '0 : count + 1'b1;
    end
  end

  // Flags are decoded from the next count so they land in the same cycle
  // as the count they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      count  <= '0;
      blank  <= 1'b0;
      sync_n <= 1'b1;
      last   <= 1'b0;
    end else begin
      count  <= nxt;
      blank  <= (nxt >= L_VIS);
      sync_n <= !((nxt >= L_SS) && (nxt <= L_SE));
      last   <= (nxt == L_LAST);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/row/frame counters with zero-skew
// registered blanking, sync and end-of-line / end-of-frame pulses.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int P_H_FRONT   = 16,
  parameter int P_H_SYNC    = 96,
  parameter int P_H_BACK    = 48,
  parameter int P_V_FRONT   = 10,
  parameter int P_V_SYNC    = 2,
  parameter int P_V_BACK    = 33,
  parameter int P_H_VISIBLE = H_VISIBLE_AREA,
  parameter int P_V_VISIBLE = V_VISIBLE_AREA
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  output logic               o_HBlank,
  output logic               o_VBlank,
  output logic               o_HReset,
  output logic               o_VReset,
  output logic               o_HSync,
  output logic               o_VSync,
  output logic [CNT_W-1:0]   o_Col,
  output logic [CNT_W-1:0]   o_Row,
  output logic [FRAME_W-1:0] o_Frame
);

  localparam int H_TOTAL      = P_H_VISIBLE + P_H_FRONT + P_H_SYNC + P_H_BACK;
  localparam int V_TOTAL      = P_V_VISIBLE + P_V_FRONT + P_V_SYNC + P_V_BACK;
  localparam int H_SYNC_START = P_H_VISIBLE + P_H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + P_H_SYNC - 1;
  localparam int V_SYNC_START = P_V_VISIBLE + P_V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + P_V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_PRE_LAST = CNT_W'(H_TOTAL - 2);

  logic v_last;

  timing_counter #(
    .TOTAL      (H_TOTAL),
    .VIS        (P_H_VISIBLE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END)
  ) u_h (
    .clock  (i_Clk),
    .reset  (i_Reset),
    .enable (1'b1),
    .count  (o_Col),
    .blank  (o_HBlank),
    .sync_n (o_HSync),
    .last   (o_HReset)
  );

  timing_counter #(
    .TOTAL      (V_TOTAL),
    .VIS        (P_V_VISIBLE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END)
  ) u_v (
    .clock  (i_Clk),
    .reset  (i_Reset),
    .enable (o_HReset),
    .count  (o_Row),
    .blank  (o_VBlank),
    .sync_n (o_VSync),
    .last   (v_last)
  );

  // Registered frame-end pulse: the next state is the last pixel of the
  // last line exactly when the current column is one short of the end.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_VReset <= 1'b0;
      o_Frame  <= '0;
    end else begin
      o_VReset <= (o_Col == H_PRE_LAST) && v_last;
      if (o_VReset) begin
        o_Frame <= o_Frame + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size and a reduced-size instance are
// compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic       d_hb, d_vb, d_hr, d_vr, d_hs, d_vs;
  logic [9:0] d_col, d_row;
  logic [7:0] d_frame;
  logic       s_hb, s_vb, s_hr, s_vr, s_hs, s_vs;
  logic [9:0] s_col, s_row;
  logic [7:0] s_frame;

  vga_timing_gen u_def (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .o_HBlank (d_hb),
    .o_VBlank (d_vb),
    .o_HReset (d_hr),
    .o_VReset (d_vr),
    .o_HSync  (d_hs),
    .o_VSync  (d_vs),
    .o_Col    (d_col),
    .o_Row    (d_row),
    .o_Frame  (d_frame)
  );

  vga_timing_gen #(
    .P_H_VISIBLE (10),
    .P_H_FRONT   (2),
    .P_H_SYNC    (2),
    .P_H_BACK    (2),
    .P_V_VISIBLE (8),
    .P_V_FRONT   (2),
    .P_V_SYNC    (2),
    .P_V_BACK    (2)
  ) u_sm (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .o_HBlank (s_hb),
    .o_VBlank (s_vb),
    .o_HReset (s_hr),
    .o_VReset (s_vr),
    .o_HSync  (s_hs),
    .o_VSync  (s_vs),
    .o_Col    (s_col),
    .o_Row    (s_row),
    .o_Frame  (s_frame)
  );

  // Raster geometry per instance: index 0 = default, 1 = reduced.
  int h_vis[2] = '{640, 10};
  int h_fp[2]  = '{16, 2};
  int h_sw[2]  = '{96, 2};
  int h_bp[2]  = '{48, 2};
  int v_vis[2] = '{480, 8};
  int v_fp[2]  = '{10, 2};
  int v_sw[2]  = '{2, 2};
  int v_bp[2]  = '{33, 2};

  int total = 0;
  int bad   = 0;
  int t     = 0;
  bit armed = 0;
  int vis_px[2];
  int vis_ln[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic compare(input int k, input logic [9:0] col, input logic [9:0] row,
                         input logic [7:0] frame, input logic hb, input logic vb,
                         input logic hr, input logic vr, input logic hs, input logic vs);
    int ht, vt, c, ln, r, f, hss, vss;
    string p;
    ht  = h_vis[k] + h_fp[k] + h_sw[k] + h_bp[k];
    vt  = v_vis[k] + v_fp[k] + v_sw[k] + v_bp[k];
    hss = h_vis[k] + h_fp[k];
    vss = v_vis[k] + v_fp[k];
    c   = t % ht;
    ln  = t / ht;
    r   = ln % vt;
    f   = (ln / vt) % 256;
    p   = (k == 0) ? "def" : "sm";
    check({p, ".col"},    32'(col),   32'(c));
    check({p, ".row"},    32'(row),   32'(r));
    check({p, ".frame"},  32'(frame), 32'(f));
    check({p, ".hblank"}, 32'(hb), 32'(c >= h_vis[k]));
    check({p, ".vblank"}, 32'(vb), 32'(r >= v_vis[k]));
    check({p, ".hreset"}, 32'(hr), 32'(c == ht - 1));
    check({p, ".vreset"}, 32'(vr), 32'((c == ht - 1) && (r == vt - 1)));
    check({p, ".hsync"},  32'(hs), 32'(!((c >= hss) && (c < hss + h_sw[k]))));
    check({p, ".vsync"},  32'(vs), 32'(!((r >= vss) && (r < vss + v_sw[k]))));
    check({p, ".col_range"}, 32'(32'(col) < ht), 32'd1);
    check({p, ".row_range"}, 32'(32'(row) < vt), 32'd1);
    // Visible pixels per line and visible lines per frame.
    if (t == 0) begin
      vis_px[k] = 0;
      vis_ln[k] = 0;
    end
    if (!hb) vis_px[k]++;
    if (hr) begin
      check({p, ".vis_px"}, 32'(vis_px[k]), 32'(h_vis[k]));
      vis_px[k] = 0;
      if (!vb) vis_ln[k]++;
    end
    if (vr) begin
      check({p, ".vis_ln"}, 32'(vis_ln[k]), 32'(v_vis[k]));
      vis_ln[k] = 0;
    end
  endtask

  task automatic step();
    logic r;
    r = rst;
    @(posedge clk);
    #1;
    if (r) begin
      t = 0;
      armed = 1;
    end else begin
      t++;
    end
    if (armed) begin
      compare(0, d_col, d_row, d_frame, d_hb, d_vb, d_hr, d_vr, d_hs, d_vs);
      compare(1, s_col, s_row, s_frame, s_hb, s_vb, s_hr, s_vr, s_hs, s_vs);
    end
  endtask

  initial begin
    bit found;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // Three full default-size lines from reset.
    repeat (2400) step();

    // Reset pulse mid-frame on the reduced raster.
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (s_col == 10'd12 && s_row == 10'd10) found = 1;
      else step();
    end
    check("wait_mid_frame", 32'(found), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (500) step();

    // Random reset pulses.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      step();
    end

    // Clean run past the 8-bit frame counter wrap on the reduced raster.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (257 * 224 + 50) step();
    check("sm.frame_after_wrap", 32'(s_frame), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
